// File: rtl/mlp_cap_pkg.sv
// rtl/mlp_cap_pkg.sv - shared types and defaults for the MLP result capture block
package mlp_cap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HELD  = 2'd2
    } cap_state_t;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;

endpackage

// File: rtl/mlp_cap_fifo.sv
// rtl/mlp_cap_fifo.sv - synchronous FIFO with sync active-low reset and sync clear
module mlp_cap_fifo
    import mlp_cap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              do_wr;
    logic              do_rd;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);

    // Head reads as zero when empty so the port is clean out of reset.
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/mlp_result_capture.sv
// rtl/mlp_result_capture.sv - captures one MLP result per finished pulse into a FIFO with stats; MLP_CAP_ARGMAX_EN adds argmax_idx
module mlp_result_capture
    import mlp_cap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mlp_out,
    input  logic              mlp_finished,
    input  logic              clear,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic [DATA_W-1:0] max_val,
    output logic              max_vld
`ifdef MLP_CAP_ARGMAX_EN
    ,
    output logic [CNT_W-1:0]  argmax_idx
`endif
);

    cap_state_t state;
    cap_state_t state_nxt;
    logic       capture;
    logic       pop;
    logic       accept;
    logic       full;
    logic       empty;
    logic       new_max;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IDLE waits for a low level so a finished already high at release is ignored.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:  if (!mlp_finished) state_nxt = ARMED;
            ARMED: if (mlp_finished) begin
                       state_nxt = HELD;
                       capture   = 1'b1;
                   end
            HELD:  if (!mlp_finished) state_nxt = ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_valid = ~empty;
    assign pop      = rd_valid & rd_ready;
    assign accept   = capture & (~full | pop);
    assign new_max  = ~max_vld || ($signed(mlp_out) > $signed(max_val));

    mlp_cap_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (accept),
        .wr_data (mlp_out),
        .full    (full),
        .rd_en   (rd_ready),
        .rd_data (rd_data),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count    <= '0;
            overflow <= 1'b0;
            max_val  <= '0;
            max_vld  <= 1'b0;
        end else if (accept) begin
            if (!(&count)) begin
                count <= count + 1'b1;
            end
            if (new_max) begin
                max_val <= mlp_out;
                max_vld <= 1'b1;
            end
        end else if (capture) begin
            overflow <= 1'b1;
        end
    end

`ifdef MLP_CAP_ARGMAX_EN
    // Strict compare in new_max keeps the earliest index on ties.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            argmax_idx <= '0;
        end else if (accept && new_max) begin
            argmax_idx <= count;
        end
    end
`endif

endmodule
